mips32_mem_responder: RTL and testbench

//  Word-addressed memory responder for the pipelined MIPS32 core. It owns the
//  1024x32 unified instruction/data store and serves two initiators: the IF

---
 rtl/mips32_mem_responder.sv | 152 +++++++++++++++
 tb/tb_mips32_mem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_responder.sv
// Unified 1024x32 instruction/data store serving the IF fetch port and the MEM data port
// through one single-port RAM, with a loader port for program preload.
module mips32_mem_responder #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic              dm_req_we,
  input  logic [31:0]       dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_rsp_valid,
  input  logic              dm_rsp_ready,
  output logic [DATA_W-1:0] dm_rsp_rdata,
  output logic              dm_rsp_err,
  input  logic              ld_en,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int STREAK_W = (MAX_STREAK > 2) ? $clog2(MAX_STREAK) : 1;
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(MAX_STREAK - 1);

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_W-1:0]   if_rsp_data_q,  if_rsp_data_d;
  logic                if_rsp_err_q,   if_rsp_err_d;
  logic                dm_rsp_valid_q, dm_rsp_valid_d;
  logic [DATA_W-1:0]   dm_rsp_rdata_q, dm_rsp_rdata_d;
  logic                dm_rsp_err_q,   dm_rsp_err_d;
  logic [STREAK_W-1:0] streak_q,       streak_d;

  logic                if_in_range, dm_in_range;
  logic                if_can, dm_can, if_favoured;
  logic                if_gnt, dm_gnt;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;

  // Request stage: acceptance and arbitration
  assign if_in_range = (if_req_addr[31:ADDR_W] == '0);
  assign dm_in_range = (dm_req_addr[31:ADDR_W] == '0);

  assign if_can      = !ld_en && (!if_rsp_valid_q || if_rsp_ready);
  assign dm_can      = !ld_en && (!dm_rsp_valid_q || dm_rsp_ready);
  assign if_favoured = (streak_q == STREAK_LIM);

  // The two grants are mutually exclusive by construction: whichever side loses
  // the tie-break sees its ready held low.
  assign if_req_ready = if_can && !(dm_req_valid && dm_can && !if_favoured);
  assign dm_req_ready = dm_can && !(if_req_valid && if_can && if_favoured);

  assign if_gnt = if_req_valid && if_req_ready;
  assign dm_gnt = dm_req_valid && dm_req_ready;

  always_comb begin
    ram_addr = ld_addr;
    if (dm_gnt) begin
      ram_addr = dm_req_addr[ADDR_W-1:0];
    end else if (if_gnt) begin
      ram_addr = if_req_addr[ADDR_W-1:0];
    end
  end

  assign ram_we    = (ld_en && ld_we) || (dm_gnt && dm_req_we && dm_in_range);
  assign ram_wdata = ld_en ? ld_data : dm_req_wdata;
  assign ram_rdata = mem[ram_addr];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always_comb begin
    if_rsp_valid_d = if_rsp_valid_q;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = if_rsp_err_q;
    if (if_gnt) begin
      if_rsp_valid_d = 1'b1;
      if_rsp_data_d  = if_in_range ? ram_rdata : '0;
      if_rsp_err_d   = !if_in_range;
    end else if (if_rsp_ready) begin
      if_rsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    dm_rsp_valid_d = dm_rsp_valid_q;
    dm_rsp_rdata_d = dm_rsp_rdata_q;
    dm_rsp_err_d   = dm_rsp_err_q;
    if (dm_gnt) begin
      dm_rsp_valid_d = 1'b1;
      dm_rsp_rdata_d = (dm_req_we || !dm_in_range) ? '0 : ram_rdata;
      dm_rsp_err_d   = !dm_in_range;
    end else if (dm_rsp_ready) begin
      dm_rsp_valid_d = 1'b0;
    end
  end

  // Saturates so a blocked fetch port cannot wrap the counter back to dm priority.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_valid || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && (streak_q != STREAK_LIM)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Response stage: registered response slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      dm_rsp_valid_q <= 1'b0;
      dm_rsp_rdata_q <= '0;
      dm_rsp_err_q   <= 1'b0;
      streak_q       <= '0;
    end else begin
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      dm_rsp_valid_q <= dm_rsp_valid_d;
      dm_rsp_rdata_q <= dm_rsp_rdata_d;
      dm_rsp_err_q   <= dm_rsp_err_d;
      streak_q       <= streak_d;
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign dm_rsp_valid = dm_rsp_valid_q;
  assign dm_rsp_rdata = dm_rsp_rdata_q;
  assign dm_rsp_err   = dm_rsp_err_q;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Scoreboard bench for mips32_mem_responder: a reference memory and arbitration model
// predicts readies and responses; scenario tasks add targeted inline checks.
module tb_mips32_mem_responder;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int MAX_STREAK = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [31:0]       if_req_addr;
  logic [DATA_W-1:0] if_rsp_data;
  logic              dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid, dm_rsp_ready, dm_rsp_err;
  logic [31:0]       dm_req_addr;
  logic [DATA_W-1:0] dm_req_wdata, dm_rsp_rdata;
  logic              ld_en, ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  always #5 clk = ~clk;

  mips32_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_ready(dm_rsp_ready), .dm_rsp_rdata(dm_rsp_rdata),
    .dm_rsp_err(dm_rsp_err),
    .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  int          checks   = 0;
  int          failures = 0;
  rsp_t        if_q[$];
  rsp_t        dm_q[$];
  logic [31:0] ref_mem [0:1023];
  int          m_streak = 0;

  task automatic idle();
    if_req_valid = 1'b0; if_req_addr = '0; if_rsp_ready = 1'b1;
    dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_addr = '0; dm_req_wdata = '0;
    dm_rsp_ready = 1'b1;
    ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  // One clock: compare against the model at the falling edge, then advance the model.
  task automatic tick();
    bit   ifc, dmc, fav, exp_ir, exp_dr, ig, dg, oor;
    rsp_t e;
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== (if_q.size() != 0)) begin
      failures++;
      $display("FAIL if_rsp_valid got=%b exp=%b t=%0t", if_rsp_valid, (if_q.size() != 0), $time);
    end
    checks++;
    if (dm_rsp_valid !== (dm_q.size() != 0)) begin
      failures++;
      $display("FAIL dm_rsp_valid got=%b exp=%b t=%0t", dm_rsp_valid, (dm_q.size() != 0), $time);
    end
    if (if_q.size() != 0) begin
      checks++;
      if ({if_rsp_err, if_rsp_data} !== if_q[0]) begin
        failures++;
        $display("FAIL if_rsp got err=%b data=%h exp err=%b data=%h t=%0t",
                 if_rsp_err, if_rsp_data, if_q[0].err, if_q[0].data, $time);
      end
    end
    if (dm_q.size() != 0) begin
      checks++;
      if ({dm_rsp_err, dm_rsp_rdata} !== dm_q[0]) begin
        failures++;
        $display("FAIL dm_rsp got err=%b data=%h exp err=%b data=%h t=%0t",
                 dm_rsp_err, dm_rsp_rdata, dm_q[0].err, dm_q[0].data, $time);
      end
    end
    ifc    = !ld_en && (if_q.size() == 0 || if_rsp_ready);
    dmc    = !ld_en && (dm_q.size() == 0 || dm_rsp_ready);
    fav    = (m_streak == MAX_STREAK - 1);
    exp_ir = ifc && !(dm_req_valid && dmc && !fav);
    exp_dr = dmc && !(if_req_valid && ifc && fav);
    if (if_req_valid) begin
      checks++;
      if (if_req_ready !== exp_ir) begin
        failures++;
        $display("FAIL if_req_ready got=%b exp=%b t=%0t", if_req_ready, exp_ir, $time);
      end
    end
    if (dm_req_valid) begin
      checks++;
      if (dm_req_ready !== exp_dr) begin
        failures++;
        $display("FAIL dm_req_ready got=%b exp=%b t=%0t", dm_req_ready, exp_dr, $time);
      end
    end
    ig = if_req_valid && exp_ir;
    dg = dm_req_valid && exp_dr;
    if (if_q.size() != 0 && if_rsp_ready) void'(if_q.pop_front());
    if (dm_q.size() != 0 && dm_rsp_ready) void'(dm_q.pop_front());
    if (ig) begin
      oor    = (if_req_addr[31:ADDR_W] != 0);
      e.err  = oor;
      e.data = oor ? 32'h0 : ref_mem[if_req_addr[ADDR_W-1:0]];
      if_q.push_back(e);
    end
    if (dg) begin
      oor   = (dm_req_addr[31:ADDR_W] != 0);
      e.err = oor;
      if (dm_req_we) begin
        e.data = 32'h0;
        if (!oor) ref_mem[dm_req_addr[ADDR_W-1:0]] = dm_req_wdata;
      end else begin
        e.data = oor ? 32'h0 : ref_mem[dm_req_addr[ADDR_W-1:0]];
      end
      dm_q.push_back(e);
    end
    if (ld_en && ld_we) ref_mem[ld_addr] = ld_data;
    if (!if_req_valid || ig) m_streak = 0;
    else if (dg && m_streak < MAX_STREAK - 1) m_streak++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #2;
    checks++;
    if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got if=%b dm=%b exp 0 0", if_rsp_valid, dm_rsp_valid);
    end
    checks++;
    if (if_rsp_data !== 32'h0 || dm_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got if=%h dm=%h exp 0 0", if_rsp_data, dm_rsp_rdata);
    end
    checks++;
    if (if_rsp_err !== 1'b0 || dm_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got if=%b dm=%b exp 0 0", if_rsp_err, dm_rsp_err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_streak = 0;
  endtask

  task automatic test_loader_fetch();
    ld_en = 1'b1;
    ld_we = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 32'd3;
    for (int i = 0; i < 128; i++) begin
      ld_addr = 10'(i);
      ld_data = 32'hA500_0000 | 32'(i);
      tick();
    end
    if_req_valid = 1'b0;
    ld_addr = 10'd5;
    ld_data = 32'h2820_0004;
    tick();
    ld_en = 1'b0;
    ld_we = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 32'd5;
    tick();
    if_req_valid = 1'b0;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h2820_0004 || if_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL ld_fetch got v=%b data=%h err=%b exp v=1 data=28200004 err=0",
               if_rsp_valid, if_rsp_data, if_rsp_err);
    end
    tick();
  endtask

  task automatic test_store_then_fetch();
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'd12; dm_req_wdata = 32'hDEAD_BEEF;
    tick();
    dm_req_valid = 1'b0; dm_req_we = 1'b0;
    checks++;
    if (dm_rsp_valid !== 1'b1 || dm_rsp_rdata !== 32'h0 || dm_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL store_ack got v=%b data=%h err=%b exp v=1 data=0 err=0",
               dm_rsp_valid, dm_rsp_rdata, dm_rsp_err);
    end
    if_req_valid = 1'b1; if_req_addr = 32'd12;
    tick();
    if_req_valid = 1'b0;
    checks++;
    if (if_rsp_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_fwd got=%h exp=deadbeef", if_rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back_arb();
    bit exp_d;
    if_req_valid = 1'b1;
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if_req_addr = 32'(32 + k);
      dm_req_addr = 32'(64 + k);
      #2;
      exp_d = ((k % 4) != 3);
      checks++;
      if (dm_req_ready !== exp_d || if_req_ready !== !exp_d) begin
        failures++;
        $display("FAIL arb_pattern k=%0d got dm=%b if=%b exp dm=%b if=%b",
                 k, dm_req_ready, if_req_ready, exp_d, !exp_d);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'd7; dm_rsp_ready = 1'b0;
    tick();
    dm_req_addr  = 32'd8;
    if_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if_req_addr = 32'(40 + k);
      #2;
      checks++;
      if (dm_req_ready !== 1'b0 || dm_rsp_valid !== 1'b1 || dm_rsp_rdata !== 32'hA500_0007) begin
        failures++;
        $display("FAIL bp_hold k=%0d got rdy=%b v=%b data=%h exp rdy=0 v=1 data=a5000007",
                 k, dm_req_ready, dm_rsp_valid, dm_rsp_rdata);
      end
      checks++;
      if (if_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_if_served k=%0d got=%b exp=1", k, if_req_ready);
      end
      tick();
    end
    if_req_valid = 1'b0;
    dm_rsp_ready = 1'b1;
    tick();
    idle();
    tick();
  endtask

  task automatic test_out_of_range();
    ld_en = 1'b1; ld_we = 1'b1; ld_addr = 10'd0; ld_data = 32'h1234_5678;
    tick();
    idle();
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h0000_0400;
    tick();
    checks++;
    if (dm_rsp_err !== 1'b1 || dm_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL oor_load got err=%b data=%h exp err=1 data=0", dm_rsp_err, dm_rsp_rdata);
    end
    dm_req_we = 1'b1; dm_req_wdata = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (dm_rsp_err !== 1'b1 || dm_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL oor_store got err=%b data=%h exp err=1 data=0", dm_rsp_err, dm_rsp_rdata);
    end
    dm_req_we = 1'b0; dm_req_addr = 32'h0;
    tick();
    checks++;
    if (dm_rsp_err !== 1'b0 || dm_rsp_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL oor_ram0 got err=%b data=%h exp err=0 data=12345678", dm_rsp_err, dm_rsp_rdata);
    end
    dm_req_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h8000_0005;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_midflight();
    if_rsp_ready = 1'b0; dm_rsp_ready = 1'b0;
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'd20; dm_req_wdata = 32'hCAFE_F00D;
    tick();
    dm_req_valid = 1'b0; dm_req_we = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'd20;
    tick();
    if_req_valid = 1'b0;
    checks++;
    if (if_rsp_valid !== 1'b1 || dm_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pending got if=%b dm=%b exp 1 1", if_rsp_valid, dm_rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_drop got if=%b dm=%b data=%h exp 0 0 0", if_rsp_valid, dm_rsp_valid, if_rsp_data);
    end
    if_q.delete();
    dm_q.delete();
    m_streak = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'd20;
    tick();
    idle();
    checks++;
    if (if_rsp_data !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL rstmid_store got=%h exp=cafef00d", if_rsp_data);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loader_fetch();
    test_store_then_fetch();
    test_back_to_back_arb();
    test_backpressure();
    test_out_of_range();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
